sky130_fd_io__refgen_multi_seq: RTL and testbench

Clocked, multi-channel sequencer for the I/O reference generators. It captures per-channel reference configuration under ENABLE_H/HLD_H_N control and times analog startup with cycle counters rather than fixed delays. It drives the leak-bias enable, readiness flags and a one-hot DFT observe select. It sits between the digital config registers and NUM_CH refgen analog slices.

---
 rtl/sky130_fd_io__refgen_pkg.sv | 40 ++++
 rtl/sky130_fd_io__refgen_ch_fsm.sv | 137 +++++++++++++
 rtl/sky130_fd_io__refgen_multi_seq.sv | 104 ++++++++++
 tb/tb_sky130_fd_io__refgen_multi_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sky130_fd_io__refgen_pkg.sv
// Shared types and encodings for the refgen multi-channel sequencer.
package sky130_fd_io__refgen_pkg;

    localparam int VOH_W = 3;

    localparam logic [1:0] VREF_VOHREF     = 2'b00;
    localparam logic [1:0] VREF_VOHREF_ALT = 2'b01;
    localparam logic [1:0] VREF_AMUXA      = 2'b10;
    localparam logic [1:0] VREF_AMUXB      = 2'b11;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        STARTUP = 2'd1,
        READY   = 2'd2
    } ch_state_e;

    typedef struct packed {
        logic             ch_en;
        logic             ibuf;
        logic             vtrip;
        logic             vreg;
        logic [1:0]       vref;
        logic [VOH_W-1:0] voh;
    } ch_cfg_t;

    // Only the plain 2'b00 encoding bypasses the internal reference path.
    function automatic logic vref_internal(input logic [1:0] sel);
        logic r;
        r = 1'b0;
        unique case (sel)
            VREF_VOHREF:     r = 1'b0;
            VREF_VOHREF_ALT: r = 1'b1;
            VREF_AMUXA:      r = 1'b1;
            VREF_AMUXB:      r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sky130_fd_io__refgen_ch_fsm.sv
// One refgen channel: config capture, bias enable, startup timer and
// ready flags.
module sky130_fd_io__refgen_ch_fsm
    import sky130_fd_io__refgen_pkg::*;
#(
    parameter int STARTUP_CYCLES = 5000,
    parameter int CNT_W          = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_h,
    input  logic             hld_h_n,
    input  ch_cfg_t          cfg,
    output logic [1:0]       vref_q,
    output logic [VOH_W-1:0] voh_q,
    output logic             ibuf_q,
    output logic             vtrip_q,
    output logic             bias_en,
    output logic             voutref_rdy,
    output logic             vinref_rdy,
    output logic             startup
);

    localparam bit NO_WAIT = (STARTUP_CYCLES == 0);
    localparam logic [CNT_W-1:0] LAST =
        NO_WAIT ? '0 : CNT_W'(STARTUP_CYCLES - 1);
    localparam ch_state_e RUN_ST = NO_WAIT ? READY : STARTUP;

    ch_cfg_t          cfg_q;
    ch_cfg_t          cfg_d;
    logic             chg;
    logic             vin_pre;
    logic             ibuf_d;
    logic             vref_int;
    logic             act;
    ch_state_e        state;
    ch_state_e        nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cfg_d = cfg_q;
        if (!enable_h) begin
            cfg_d = '0;
        end else if (hld_h_n) begin
            cfg_d = cfg;
        end
    end

    // chg flags a source/level change the cycle the new value lands in cfg_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
            chg   <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            chg   <= (cfg_d.vref != cfg_q.vref) || (cfg_d.voh != cfg_q.voh);
        end
    end

    assign vref_int = vref_internal(cfg_q.vref);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_en <= 1'b0;
            vin_pre <= 1'b0;
            ibuf_d  <= 1'b0;
        end else begin
            bias_en <= cfg_q.vreg | (cfg_q.ibuf & vref_int);
            vin_pre <= cfg_q.ibuf & (cfg_q.vtrip | !vref_int);
            ibuf_d  <= cfg_q.ibuf;
        end
    end

    assign act = cfg_q.ch_en & bias_en;

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        unique case (state)
            OFF: begin
                cnt_nxt = '0;
                if (act) begin
                    nxt = RUN_ST;
                end
            end
            STARTUP: begin
                if (!act) begin
                    nxt     = OFF;
                    cnt_nxt = '0;
                end else if (chg) begin
                    nxt     = RUN_ST;
                    cnt_nxt = '0;
                end else if (NO_WAIT || cnt == LAST) begin
                    nxt = READY;
                end else if (cnt != {CNT_W{1'b1}}) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            READY: begin
                if (!act) begin
                    nxt     = OFF;
                    cnt_nxt = '0;
                end else if (chg) begin
                    nxt     = RUN_ST;
                    cnt_nxt = '0;
                end
            end
            default: begin
                nxt     = OFF;
                cnt_nxt = '0;
            end
        endcase
    end

    // Flags follow the next state so they move in the same cycle as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OFF;
            cnt         <= '0;
            voutref_rdy <= 1'b0;
            vinref_rdy  <= 1'b0;
        end else begin
            state       <= nxt;
            cnt         <= cnt_nxt;
            voutref_rdy <= (nxt == READY);
            vinref_rdy  <= vin_pre | (ibuf_d & (nxt == READY));
        end
    end

    assign startup = (nxt == STARTUP);
    assign vref_q  = cfg_q.vref;
    assign voh_q   = cfg_q.voh;
    assign ibuf_q  = cfg_q.ibuf;
    assign vtrip_q = cfg_q.vtrip;

endmodule

// File: rtl/sky130_fd_io__refgen_multi_seq.sv
// Multi-channel refgen sequencer: NUM_CH channel slices plus DFT
// observe decode and the shared BUSY flag.
module sky130_fd_io__refgen_multi_seq
    import sky130_fd_io__refgen_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int STARTUP_CYCLES = 5000,
    parameter int SEL_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    CLK,
    input  logic                    RESET_B,
    input  logic                    ENABLE_H,
    input  logic                    HLD_H_N,
    input  logic [NUM_CH-1:0]       CH_EN,
    input  logic [NUM_CH-1:0]       IBUF_SEL,
    input  logic [NUM_CH-1:0]       VTRIP_SEL,
    input  logic [NUM_CH-1:0]       VREG_EN,
    input  logic [2*NUM_CH-1:0]     VREF_SEL,
    input  logic [VOH_W*NUM_CH-1:0] VOH_SEL,
    input  logic                    DFT_REFGEN,
    input  logic [SEL_W-1:0]        DFT_CH_SEL,
    output logic [2*NUM_CH-1:0]     VREF_SEL_Q,
    output logic [VOH_W*NUM_CH-1:0] VOH_SEL_Q,
    output logic [NUM_CH-1:0]       IBUF_SEL_Q,
    output logic [NUM_CH-1:0]       VTRIP_SEL_Q,
    output logic [NUM_CH-1:0]       REFLEAK_BIAS_EN,
    output logic [NUM_CH-1:0]       VOUTREF_RDY,
    output logic [NUM_CH-1:0]       VINREF_RDY,
    output logic [NUM_CH-1:0]       DFT_EN,
    output logic                    BUSY
);

    localparam int CNT_RAW = $clog2(STARTUP_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;

    logic [NUM_CH-1:0] startup;
    logic [NUM_CH-1:0] dft_dec;
    logic              dft_q;
    logic [SEL_W-1:0]  dsel_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_cfg_t cfg;

        assign cfg = '{
            ch_en: CH_EN[i],
            ibuf:  IBUF_SEL[i],
            vtrip: VTRIP_SEL[i],
            vreg:  VREG_EN[i],
            vref:  VREF_SEL[2*i +: 2],
            voh:   VOH_SEL[VOH_W*i +: VOH_W]
        };

        sky130_fd_io__refgen_ch_fsm #(
            .STARTUP_CYCLES(STARTUP_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk        (CLK),
            .rst_n      (RESET_B),
            .enable_h   (ENABLE_H),
            .hld_h_n    (HLD_H_N),
            .cfg        (cfg),
            .vref_q     (VREF_SEL_Q[2*i +: 2]),
            .voh_q      (VOH_SEL_Q[VOH_W*i +: VOH_W]),
            .ibuf_q     (IBUF_SEL_Q[i]),
            .vtrip_q    (VTRIP_SEL_Q[i]),
            .bias_en    (REFLEAK_BIAS_EN[i]),
            .voutref_rdy(VOUTREF_RDY[i]),
            .vinref_rdy (VINREF_RDY[i]),
            .startup    (startup[i])
        );
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            dft_q  <= 1'b0;
            dsel_q <= '0;
        end else if (!ENABLE_H) begin
            dft_q  <= 1'b0;
            dsel_q <= '0;
        end else if (HLD_H_N) begin
            dft_q  <= DFT_REFGEN;
            dsel_q <= DFT_CH_SEL;
        end
    end

    // Out-of-range selects match no channel and decode to all zero.
    always_comb begin
        dft_dec = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            dft_dec[k] = dft_q && (dsel_q == SEL_W'(k));
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            DFT_EN <= '0;
            BUSY   <= 1'b0;
        end else begin
            DFT_EN <= dft_dec;
            BUSY   <= |startup;
        end
    end

endmodule

// File: tb/tb_sky130_fd_io__refgen_multi_seq.sv
// Scoreboard bench for the refgen sequencer: an age-based reference
// model predicts every output each cycle.
module tb_sky130_fd_io__refgen_multi_seq;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_h;
    logic       hld;
    logic [1:0] ch_en;
    logic [1:0] ibuf;
    logic [1:0] vtrip;
    logic [1:0] vreg;
    logic [3:0] vref;
    logic [5:0] voh;
    logic       dft;
    logic       dsel;
    logic [1:0] dsel3;

    logic [3:0] vref_q;
    logic [5:0] voh_q;
    logic [1:0] ibuf_q;
    logic [1:0] vtrip_q;
    logic [1:0] leak;
    logic [1:0] vout;
    logic [1:0] vin;
    logic [1:0] dft_en;
    logic       busy;

    logic [5:0] d3_vref_q;
    logic [8:0] d3_voh_q;
    logic [2:0] d3_ibuf_q;
    logic [2:0] d3_vtrip_q;
    logic [2:0] d3_leak;
    logic [2:0] d3_vout;
    logic [2:0] d3_vin;
    logic [2:0] d3_dft_en;
    logic       d3_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sky130_fd_io__refgen_multi_seq #(
        .NUM_CH(2),
        .STARTUP_CYCLES(N)
    ) dut (
        .CLK(clk), .RESET_B(rst_n), .ENABLE_H(en_h), .HLD_H_N(hld),
        .CH_EN(ch_en), .IBUF_SEL(ibuf), .VTRIP_SEL(vtrip), .VREG_EN(vreg),
        .VREF_SEL(vref), .VOH_SEL(voh), .DFT_REFGEN(dft), .DFT_CH_SEL(dsel),
        .VREF_SEL_Q(vref_q), .VOH_SEL_Q(voh_q), .IBUF_SEL_Q(ibuf_q),
        .VTRIP_SEL_Q(vtrip_q), .REFLEAK_BIAS_EN(leak), .VOUTREF_RDY(vout),
        .VINREF_RDY(vin), .DFT_EN(dft_en), .BUSY(busy)
    );

    sky130_fd_io__refgen_multi_seq #(
        .NUM_CH(3),
        .STARTUP_CYCLES(N)
    ) dut3 (
        .CLK(clk), .RESET_B(rst_n), .ENABLE_H(en_h), .HLD_H_N(hld),
        .CH_EN(3'b000), .IBUF_SEL(3'b000), .VTRIP_SEL(3'b000),
        .VREG_EN(3'b000), .VREF_SEL(6'b0), .VOH_SEL(9'b0),
        .DFT_REFGEN(dft), .DFT_CH_SEL(dsel3),
        .VREF_SEL_Q(d3_vref_q), .VOH_SEL_Q(d3_voh_q), .IBUF_SEL_Q(d3_ibuf_q),
        .VTRIP_SEL_Q(d3_vtrip_q), .REFLEAK_BIAS_EN(d3_leak),
        .VOUTREF_RDY(d3_vout), .VINREF_RDY(d3_vin), .DFT_EN(d3_dft_en),
        .BUSY(d3_busy)
    );

    typedef struct packed {
        logic [3:0] vref_q;
        logic [5:0] voh_q;
        logic [1:0] ibuf_q;
        logic [1:0] vtrip_q;
        logic [1:0] leak;
        logic [1:0] vout;
        logic [1:0] vin;
        logic [1:0] dft_en;
        logic       busy;
        logic [2:0] dft3;
    } exp_t;

    typedef struct packed {
        logic       ch_en;
        logic       ibuf;
        logic       vtrip;
        logic       vreg;
        logic [1:0] vref;
        logic [2:0] voh;
    } mcfg_t;

    exp_t sbq[$];

    // Model history: q0 = captured now, q1 = one cycle ago, q2 = two ago.
    mcfg_t      q0[2];
    mcfg_t      q1[2];
    mcfg_t      q2[2];
    int         run[2];
    logic       dq0, dq1, sq0, sq1;
    logic [1:0] s3q0, s3q1;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] x);
        n_tests++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
        end
    endtask

    function automatic mcfg_t inp(input int c);
        mcfg_t r;
        r.ch_en = ch_en[c];
        r.ibuf  = ibuf[c];
        r.vtrip = vtrip[c];
        r.vreg  = vreg[c];
        r.vref  = vref[2*c +: 2];
        r.voh   = voh[3*c +: 3];
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            q0[c] = '0;
            q1[c] = '0;
            q2[c] = '0;
            run[c] = 0;
        end
        dq0 = 0; dq1 = 0; sq0 = 0; sq1 = 0; s3q0 = 0; s3q1 = 0;
    endtask

    // run[c] = consecutive active cycles since the last enable or config change.
    task automatic model_step(output exp_t e);
        logic bias, act, chg, rdy, st, vi;
        e = '0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            q2[c] = q1[c];
            q1[c] = q0[c];
            q0[c] = !en_h ? '0 : (hld ? inp(c) : q1[c]);
        end
        dq1 = dq0; sq1 = sq0; s3q1 = s3q0;
        dq0  = !en_h ? 1'b0 : (hld ? dft : dq1);
        sq0  = !en_h ? 1'b0 : (hld ? dsel : sq1);
        s3q0 = !en_h ? 2'b0 : (hld ? dsel3 : s3q1);
        for (int c = 0; c < 2; c++) begin
            bias = q1[c].vreg | (q1[c].ibuf & (q1[c].vref != 2'b00));
            act  = q0[c].ch_en & bias;
            chg  = (q0[c].vref != q1[c].vref) || (q0[c].voh != q1[c].voh);
            rdy  = run[c] >= N + 1;
            st   = run[c] >= 1 && run[c] <= N;
            if (!act) run[c] = 0;
            else if (chg) run[c] = 1;
            else run[c] = (run[c] >= N + 1) ? N + 1 : run[c] + 1;
            vi = q2[c].ibuf & (q2[c].vtrip | (q2[c].vref == 2'b00) | rdy);
            e.vref_q[2*c +: 2] = q0[c].vref;
            e.voh_q[3*c +: 3]  = q0[c].voh;
            e.ibuf_q[c]  = q0[c].ibuf;
            e.vtrip_q[c] = q0[c].vtrip;
            e.leak[c]    = bias;
            e.vout[c]    = rdy;
            e.vin[c]     = vi;
            e.busy       = e.busy | st;
        end
        e.dft_en = dq1 ? (2'b01 << sq1) : 2'b00;
        e.dft3   = (dq1 && s3q1 < 2'd3) ? (3'b001 << s3q1) : 3'b000;
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_step(e);
        sbq.push_back(e);
        @(negedge clk);
    endtask

    // Drop RESET_B between edges; outputs must clear without a clock.
    task automatic async_reset();
        exp_t e;
        @(posedge clk);
        model_step(e);
        sbq.push_back(e);
        #1 rst_n = 1'b0;
        model_reset();
        void'(sbq.pop_back());
        sbq.push_back('0);
        #1 chk("async_rst",
               32'({vref_q, voh_q, ibuf_q, vtrip_q, leak, vout, vin, dft_en, busy}),
               32'd0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("vref_q",  32'(vref_q),  32'(e.vref_q));
            chk("voh_q",   32'(voh_q),   32'(e.voh_q));
            chk("ibuf_q",  32'(ibuf_q),  32'(e.ibuf_q));
            chk("vtrip_q", 32'(vtrip_q), 32'(e.vtrip_q));
            chk("leak",    32'(leak),    32'(e.leak));
            chk("voutref", 32'(vout),    32'(e.vout));
            chk("vinref",  32'(vin),     32'(e.vin));
            chk("dft_en",  32'(dft_en),  32'(e.dft_en));
            chk("busy",    32'(busy),    32'(e.busy));
            chk("dft3_en", 32'(d3_dft_en), 32'(e.dft3));
            chk("d3_quiet", 32'(|{d3_vref_q, d3_voh_q, d3_ibuf_q, d3_vtrip_q,
                                   d3_leak, d3_vout, d3_vin, d3_busy}), 32'd0);
        end
    end

    initial begin
        int c, r;
        rst_n = 0; en_h = 0; hld = 0;
        ch_en = 0; ibuf = 0; vtrip = 0; vreg = 0; vref = 0; voh = 0;
        dft = 0; dsel = 0; dsel3 = 0;
        model_reset();
        step();
        step();
        rst_n = 1;
        step();

        en_h = 1; hld = 1;
        ch_en[0] = 1; vreg[0] = 1; vref[1:0] = 2'b01; voh[2:0] = 3'b010;
        repeat (14) step();

        ibuf[1] = 1; vref[3:2] = 2'b10; vtrip[1] = 1; ch_en[1] = 1;
        repeat (14) step();

        voh[2:0] = 3'b101;
        repeat (12) step();

        voh[2:0] = 3'b010;
        repeat (4) step();
        hld = 0; vref[1:0] = 2'b11;
        repeat (12) step();
        hld = 1;
        repeat (14) step();

        dft = 1; dsel = 1; dsel3 = 2'd3;
        repeat (3) step();
        dsel3 = 2'd2;
        repeat (2) step();
        dsel = 0; dsel3 = 2'd0;
        repeat (2) step();

        en_h = 0;
        repeat (4) step();
        en_h = 1;
        repeat (5) step();
        async_reset();
        repeat (14) step();

        for (int i = 0; i < 600; i++) begin
            c = int'($urandom_range(1));
            r = int'($urandom_range(63));
            case (r)
                0: ch_en[c] = ~ch_en[c];
                1: ibuf[c] = ~ibuf[c];
                2: vtrip[c] = ~vtrip[c];
                3: vreg[c] = ~vreg[c];
                4: vref[2*c +: 2] = 2'($urandom_range(3));
                5: voh[3*c +: 3] = 3'($urandom_range(7));
                6: hld = 0;
                7, 8, 9: hld = 1;
                10: en_h = 0;
                11, 12, 13: en_h = 1;
                14: dft = ~dft;
                15: dsel = ~dsel;
                16: dsel3 = 2'($urandom_range(3));
                17: if ((i % 4) == 0) async_reset();
                default: ;
            endcase
            step();
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
